// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// One digit is enabled per scan slot; all time inputs and the view select
// are captured once per frame so a frame never mixes old and new values.
// Digit 2 carries a decimal point that blinks at 1 Hz, derived from msec.

module fnd_scan_controller #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BIT_100HZ = 100,
  parameter int SECOND_60 = 60,
  parameter int HOUR      = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(BIT_100HZ)-1:0] msec,
  input  logic [$clog2(SECOND_60)-1:0] sec,
  input  logic [$clog2(SECOND_60)-1:0] min,
  input  logic [$clog2(HOUR)-1:0]      hour,
  input  logic                         disp_sel,
  output logic [3:0]                   fnd_com,
  output logic [7:0]                   fnd_font
);

  localparam int MSEC_W  = $clog2(BIT_100HZ);
  localparam int SEC_W   = $clog2(SECOND_60);
  localparam int HOUR_W  = $clog2(HOUR);
  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FIELD_W = 7;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [FIELD_W-1:0] DP_HALF  = FIELD_W'(50);
  localparam logic [1:0]         IDX_LAST = 2'd3;
  localparam logic [1:0]         IDX_DP   = 2'd2;

  // Tens digit of a 7-bit value by comparator chain (0..12 for 0..127),
  // avoiding a real divider.
  function automatic logic [3:0] dec_tens(input logic [FIELD_W-1:0] v);
    logic [3:0] t;
    t = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      if (v >= FIELD_W'(10 * k)) t = 4'(k);
    end
    return t;
  endfunction

  // Ones digit: remainder after removing the tens found above.
  function automatic logic [3:0] dec_ones(input logic [FIELD_W-1:0] v);
    logic [FIELD_W-1:0] r;
    r = v - FIELD_W'(dec_tens(v)) * FIELD_W'(10);
    return 4'(r);
  endfunction

  // Active-low segment pattern with dp off; anything above 9 is blank.
  function automatic logic [7:0] seg_font(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'd0:    f = 8'hC0;
      4'd1:    f = 8'hF9;
      4'd2:    f = 8'hA4;
      4'd3:    f = 8'hB0;
      4'd4:    f = 8'h99;
      4'd5:    f = 8'h92;
      4'd6:    f = 8'h82;
      4'd7:    f = 8'hF8;
      4'd8:    f = 8'h80;
      4'd9:    f = 8'h90;
      default: f = 8'hFF;
    endcase
    return f;
  endfunction

  logic [CNT_W-1:0]   scan_cnt;
  logic               scan_tick;
  logic [1:0]         idx;
  logic               started;

  logic [MSEC_W-1:0]  sh_msec;
  logic [SEC_W-1:0]   sh_sec;
  logic [SEC_W-1:0]   sh_min;
  logic [HOUR_W-1:0]  sh_hour;
  logic               sh_sel;

  logic [FIELD_W-1:0] low_field;
  logic [FIELD_W-1:0] high_field;
  logic [3:0]         digit;
  logic               dp_on;
  logic [3:0]         com_d;
  logic [7:0]         font_d;

  assign scan_tick = (scan_cnt == CNT_LAST);

  // Slot timer: free-running 0..SCAN_DIV-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
    end else if (scan_tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit index; starts at 3 so the first slot wraps to 0 and latches data.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= IDX_LAST;
    end else if (scan_tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Keeps the pins blank until the first real slot has begun.
  always_ff @(posedge clk) begin
    if (reset) begin
      started <= 1'b0;
    end else if (scan_tick) begin
      started <= 1'b1;
    end
  end

  // Frame latch: inputs are captured only at the idx 3 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_msec <= '0;
      sh_sec  <= '0;
      sh_min  <= '0;
      sh_hour <= '0;
      sh_sel  <= 1'b0;
    end else if (scan_tick && (idx == IDX_LAST)) begin
      sh_msec <= msec;
      sh_sec  <= sec;
      sh_min  <= min;
      sh_hour <= hour;
      sh_sel  <= disp_sel;
    end
  end

  // View select: choose low/high fields from the shadow copy.
  always_comb begin
    low_field  = FIELD_W'(sh_msec);
    high_field = FIELD_W'(sh_sec);
    if (sh_sel) begin
      low_field  = FIELD_W'(sh_min);
      high_field = FIELD_W'(sh_hour);
    end
  end

  // Pick the decimal digit for the current slot.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0:    digit = dec_ones(low_field);
      2'd1:    digit = dec_tens(low_field);
      2'd2:    digit = dec_ones(high_field);
      default: digit = dec_tens(high_field);
    endcase
  end

  // Next pin values: digit enable, font, and the blinking dp on digit 2.
  always_comb begin
    dp_on  = (idx == IDX_DP) && (FIELD_W'(sh_msec) < DP_HALF);
    com_d  = ~(4'b0001 << idx);
    font_d = seg_font(digit);
    if (dp_on) font_d[7] = 1'b0;
  end

  // Registered pins; one cycle behind idx.
  always_ff @(posedge clk) begin
    if (reset || !started) begin
      fnd_com  <= 4'b1111;
      fnd_font <= 8'hFF;
    end else begin
      fnd_com  <= com_d;
      fnd_font <= font_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller with a short scan slot.
// Expected digit frames are queued as inputs are applied and popped as
// each new digit appears on the pins.

module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] msec = '0;
  logic [5:0] sec = '0;
  logic [5:0] min = '0;
  logic [4:0] hour = '0;
  logic       disp_sel = 1'b0;
  logic [3:0] fnd_com;
  logic [7:0] fnd_font;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .msec     (msec),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .disp_sel (disp_sel),
    .fnd_com  (fnd_com),
    .fnd_font (fnd_font)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] last_com = 4'b1111;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] com_exp, input logic [7:0] font_exp);
    n_vec++;
    assert (fnd_com === com_exp) else begin
      n_err++;
      $error("FAIL %s fnd_com observed=%b expected=%b", tag, fnd_com, com_exp);
    end
    n_vec++;
    assert (fnd_font === font_exp) else begin
      n_err++;
      $error("FAIL %s fnd_font observed=%h expected=%h", tag, fnd_font, font_exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] f0, input logic [7:0] f1,
                            input logic [7:0] f2, input logic [7:0] f3);
    sb.push_back('{com: 4'b1110, font: f0});
    sb.push_back('{com: 4'b1101, font: f1});
    sb.push_back('{com: 4'b1011, font: f2});
    sb.push_back('{com: 4'b0111, font: f3});
  endtask

  // Wait (bounded) for the next digit to appear, then compare with the queue head.
  task automatic pop_check(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    do begin
      step(1);
      n++;
    end while (fnd_com === last_com && n < budget);
    n_vec++;
    assert (fnd_com !== last_com) else begin
      n_err++;
      $error("FAIL %s_timeout fnd_com observed=%b expected=change within %0d cycles", tag, fnd_com, budget);
    end
    n_vec++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(tag, e.com, e.font);
    end
    last_com = fnd_com;
  endtask

  task automatic pop_frame(input string tag);
    for (int i = 0; i < 4; i++) pop_check($sformatf("%s_d%0d", tag, i), SCAN_DIV);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and release timing
    reset = 1'b1; disp_sel = 1'b0; msec = 7'd37; sec = 6'd42;
    step(3);
    check("reset_hold", 4'b1111, 8'hFF);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check($sformatf("blank_c%0d", i), 4'b1111, 8'hFF);
    end
    last_com = 4'b1111;

    // sec.msec view, dp lit (msec 37)
    push_frame(8'hF8, 8'hB0, 8'h24, 8'h99);
    pop_check("secmsec_d0", 1);
    for (int i = 1; i < 4; i++) pop_check($sformatf("secmsec_d%0d", i), SCAN_DIV);

    // hour.min view, dp off (msec 75); view change mid-frame is deferred
    disp_sel = 1'b1; hour = 5'd23; min = 6'd59; msec = 7'd75;
    push_frame(8'h90, 8'h92, 8'hB0, 8'hA4);
    pop_check("hourmin_d0", SCAN_DIV);
    pop_check("hourmin_d1", SCAN_DIV);
    disp_sel = 1'b0; msec = 7'd60; sec = 6'd59;
    pop_check("hourmin_d2", SCAN_DIV);
    pop_check("hourmin_d3", SCAN_DIV);

    // Tear check: sec 59 -> 0 while idx = 1
    push_frame(8'hC0, 8'h82, 8'h90, 8'h92);
    pop_check("tear_d0", SCAN_DIV);
    pop_check("tear_d1", SCAN_DIV);
    sec = 6'd0;
    pop_check("tear_d2", SCAN_DIV);
    pop_check("tear_d3", SCAN_DIV);
    push_frame(8'hC0, 8'h82, 8'hC0, 8'hC0);
    pop_frame("tear_next");

    // Out of range msec 120
    msec = 7'd120;
    push_frame(8'hC0, 8'hFF, 8'hC0, 8'hC0);
    pop_frame("oor");

    // dp boundary: 49 lit, 50 off
    msec = 7'd49; sec = 6'd7;
    push_frame(8'h90, 8'h99, 8'h78, 8'hC0);
    pop_frame("dp49");
    msec = 7'd50;
    push_frame(8'hC0, 8'h92, 8'hF8, 8'hC0);
    pop_frame("dp50");

    // Mid-frame reset while idx = 2
    push_frame(8'hC0, 8'h92, 8'hF8, 8'hC0);
    pop_check("prerst_d0", SCAN_DIV);
    pop_check("prerst_d1", SCAN_DIV);
    pop_check("prerst_d2", SCAN_DIV);
    void'(sb.pop_front());
    reset = 1'b1;
    step(1);
    check("midrst", 4'b1111, 8'hFF);
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check($sformatf("rstblank_c%0d", i), 4'b1111, 8'hFF);
    end
    last_com = 4'b1111;
    push_frame(8'hC0, 8'h92, 8'hF8, 8'hC0);
    pop_check("postrst_d0", 1);
    for (int i = 1; i < 4; i++) pop_check($sformatf("postrst_d%0d", i), SCAN_DIV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
